// File: rtl/mem_port_arbiter_if.sv
// Signal bundle joining the CPU fetch/data requesters, the shared memory port and the arbiter.
// slave is the arbiter's view; master is the view of the requesters and memory around it.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned BE_W = DATA_W / 8;

   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [BE_W-1:0]   d_be;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;

   logic              err;
   logic              busy;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [BE_W-1:0]   mem_be;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
      output i_ack, i_rdata, d_ack, d_rdata, err, busy,
             mem_req, mem_we, mem_addr, mem_wdata, mem_be
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata, err, busy,
             mem_req, mem_we, mem_addr, mem_wdata, mem_be
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory port between instruction fetch (I)
// and data (D) requesters, with a watchdog that aborts accesses the memory never completes.
module mem_port_arbiter #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       TIMEOUT  = 255,
   parameter logic [DATA_W-1:0] ERR_DATA = '0
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);
   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

   state_t            r_state,     w_state;
   logic              r_last_d,    w_last_d;
   logic [CNT_W-1:0]  r_cnt,       w_cnt;
   logic              r_mem_req,   w_mem_req;
   logic              r_mem_we,    w_mem_we;
   logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
   logic [BE_W-1:0]   r_mem_be,    w_mem_be;
   logic              r_i_ack,     w_i_ack;
   logic              r_d_ack,     w_d_ack;
   logic              r_err,       w_err;
   logic [DATA_W-1:0] r_i_rdata,   w_i_rdata;
   logic [DATA_W-1:0] r_d_rdata,   w_d_rdata;
   logic              r_busy,      w_busy;
   logic              w_gnt_d;

   // D wins a tie unless it had the previous grant; r_last_d also marks the side in flight.
   assign w_gnt_d = bus.d_req & (~bus.i_req | ~r_last_d);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_last_d    <= 1'b0;
         r_cnt       <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
         r_i_ack     <= 1'b0;
         r_d_ack     <= 1'b0;
         r_err       <= 1'b0;
         r_i_rdata   <= '0;
         r_d_rdata   <= '0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_last_d    <= w_last_d;
         r_cnt       <= w_cnt;
         r_mem_req   <= w_mem_req;
         r_mem_we    <= w_mem_we;
         r_mem_addr  <= w_mem_addr;
         r_mem_wdata <= w_mem_wdata;
         r_mem_be    <= w_mem_be;
         r_i_ack     <= w_i_ack;
         r_d_ack     <= w_d_ack;
         r_err       <= w_err;
         r_i_rdata   <= w_i_rdata;
         r_d_rdata   <= w_d_rdata;
         r_busy      <= w_busy;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_last_d    = r_last_d;
      w_cnt       = r_cnt;
      w_mem_req   = r_mem_req;
      w_mem_we    = r_mem_we;
      w_mem_addr  = r_mem_addr;
      w_mem_wdata = r_mem_wdata;
      w_mem_be    = r_mem_be;
      w_i_ack     = 1'b0;
      w_d_ack     = 1'b0;
      w_err       = 1'b0;
      w_i_rdata   = r_i_rdata;
      w_d_rdata   = r_d_rdata;

      case (r_state)
         S_IDLE: begin
            if (bus.i_req || bus.d_req) begin
               w_last_d  = w_gnt_d;
               w_mem_req = 1'b1;
               w_cnt     = '0;
               w_state   = S_ISSUE;
               if (w_gnt_d) begin
                  w_mem_we    = bus.d_we;
                  w_mem_addr  = bus.d_addr;
                  w_mem_wdata = bus.d_wdata;
                  w_mem_be    = bus.d_we ? bus.d_be : {BE_W{1'b1}};
               end else begin
                  w_mem_we    = 1'b0;
                  w_mem_addr  = bus.i_addr;
                  w_mem_wdata = '0;
                  w_mem_be    = {BE_W{1'b1}};
               end
            end
         end

         S_ISSUE: begin
            // A ready on the last watchdog cycle still counts as a normal completion.
            if (bus.mem_ready) begin
               w_mem_req = 1'b0;
               w_state   = S_RESP;
               w_i_ack   = ~r_last_d;
               w_d_ack   = r_last_d;
               if (!r_mem_we) begin
                  if (r_last_d) w_d_rdata = bus.mem_rdata;
                  else          w_i_rdata = bus.mem_rdata;
               end
            end else if (r_cnt == CNT_LAST) begin
               w_mem_req = 1'b0;
               w_state   = S_RESP;
               w_err     = 1'b1;
               w_i_ack   = ~r_last_d;
               w_d_ack   = r_last_d;
               if (r_last_d) w_d_rdata = ERR_DATA;
               else          w_i_rdata = ERR_DATA;
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end

         S_RESP: begin
            w_state = S_IDLE;
         end

         default: begin
            w_state   = S_IDLE;
            w_mem_req = 1'b0;
         end
      endcase

      w_busy = (w_state != S_IDLE);
   end

   assign bus.i_ack     = r_i_ack;
   assign bus.d_ack     = r_d_ack;
   assign bus.i_rdata   = r_i_rdata;
   assign bus.d_rdata   = r_d_rdata;
   assign bus.err       = r_err;
   assign bus.busy      = r_busy;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_be    = r_mem_be;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a queue-based reference model predicts every
// memory-side transaction and acknowledge; independent monitor and memory responder processes.
module tb_mem_port_arbiter;
   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned TIMEOUT   = 4;
   localparam logic [31:0] ERR_DATA  = 32'h0000_0000;
   localparam int          LONG_WAIT = 99;

   typedef struct {
      bit          is_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          high;
   } mem_exp_t;

   typedef struct {
      bit          is_d;
      bit          err;
      logic [31:0] i_rdata;
      logic [31:0] d_rdata;
   } ack_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT),
      .ERR_DATA(ERR_DATA)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   mem_exp_t    mem_q[$];
   ack_exp_t    ack_q[$];
   int          lat_q[$];
   logic [31:0] model_mem [256];
   logic [31:0] phys_mem  [256];
   bit          m_last_d;
   logic [31:0] m_i_rdata;
   logic [31:0] m_d_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   // Reference model: applies one access in grant order and queues what must be observed.
   task automatic predict(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int lat);
      mem_exp_t   me;
      ack_exp_t   ae;
      bit         to;
      logic [7:0] idx;
      to       = (lat >= int'(TIMEOUT));
      idx      = addr[9:2];
      me.is_d  = is_d;
      me.we    = we;
      me.addr  = addr;
      me.wdata = wdata;
      me.be    = we ? be : 4'hF;
      me.high  = to ? int'(TIMEOUT) : lat + 1;
      if (to) begin
         if (is_d) m_d_rdata = ERR_DATA;
         else      m_i_rdata = ERR_DATA;
      end else if (we) begin
         model_mem[idx] = merge(model_mem[idx], wdata, be);
      end else if (is_d) begin
         m_d_rdata = model_mem[idx];
      end else begin
         m_i_rdata = model_mem[idx];
      end
      ae.is_d    = is_d;
      ae.err     = to;
      ae.i_rdata = m_i_rdata;
      ae.d_rdata = m_d_rdata;
      mem_q.push_back(me);
      ack_q.push_back(ae);
      lat_q.push_back(lat);
   endtask

   task automatic model_reset();
      m_last_d  = 1'b0;
      m_i_rdata = 32'h0;
      m_d_rdata = 32'h0;
      mem_q.delete();
      ack_q.delete();
      lat_q.delete();
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_mem_req"},   32'(bus.mem_req),   32'h0);
      chk({tag, "_busy"},      32'(bus.busy),      32'h0);
      chk({tag, "_i_ack"},     32'(bus.i_ack),     32'h0);
      chk({tag, "_d_ack"},     32'(bus.d_ack),     32'h0);
      chk({tag, "_err"},       32'(bus.err),       32'h0);
      chk({tag, "_mem_we"},    32'(bus.mem_we),    32'h0);
      chk({tag, "_mem_addr"},  bus.mem_addr,       32'h0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata,      32'h0);
      chk({tag, "_mem_be"},    32'(bus.mem_be),    32'h0);
      chk({tag, "_i_rdata"},   bus.i_rdata,        32'h0);
      chk({tag, "_d_rdata"},   bus.d_rdata,        32'h0);
   endtask

   // Memory responder: waits the scheduled number of cycles, then answers for one cycle.
   initial begin
      int         wait_n;
      bit         act;
      logic [7:0] idx;
      act           = 1'b0;
      wait_n        = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (rst || !bus.mem_req) begin
            act           = 1'b0;
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
         end else begin
            if (!act) begin
               act    = 1'b1;
               wait_n = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
            end
            if (wait_n == 0) begin
               idx           = bus.mem_addr[9:2];
               bus.mem_ready = 1'b1;
               if (bus.mem_we) begin
                  phys_mem[idx] = merge(phys_mem[idx], bus.mem_wdata, bus.mem_be);
                  bus.mem_rdata = $urandom;
               end else begin
                  bus.mem_rdata = phys_mem[idx];
               end
            end else begin
               wait_n--;
               bus.mem_ready = 1'b0;
               bus.mem_rdata = $urandom;
            end
         end
      end
   end

   // Monitor: checks each memory transaction and each acknowledge against the scoreboard.
   bit       mon_active = 1'b0;
   bit       mon_valid  = 1'b0;
   bit       mon_stable = 1'b1;
   int       mon_cnt    = 0;
   mem_exp_t mon_cur;

   always @(negedge clk) begin
      ack_exp_t ae;
      if (rst) begin
         mon_active = 1'b0;
      end else begin
         if (bus.mem_req && !mon_active) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
            mon_stable = 1'b1;
            if (mem_q.size() == 0) begin
               mon_valid = 1'b0;
               checks++;
               errors++;
               $display("FAIL mem_unexpected: mem_req=1 addr=0x%08h with no access expected", bus.mem_addr);
            end else begin
               mon_valid = 1'b1;
               mon_cur   = mem_q.pop_front();
               chk("mem_addr", bus.mem_addr, mon_cur.addr);
               chk("mem_we", 32'(bus.mem_we), 32'(mon_cur.we));
               chk("mem_be", 32'(bus.mem_be), 32'(mon_cur.be));
               if (mon_cur.we) chk("mem_wdata", bus.mem_wdata, mon_cur.wdata);
            end
         end
         if (bus.mem_req) begin
            mon_cnt++;
            if (mon_valid && (bus.mem_addr !== mon_cur.addr || bus.mem_we !== mon_cur.we ||
                              bus.mem_be !== mon_cur.be || !bus.busy ||
                              (mon_cur.we && bus.mem_wdata !== mon_cur.wdata)))
               mon_stable = 1'b0;
         end else if (mon_active) begin
            mon_active = 1'b0;
            if (mon_valid) begin
               chk("mem_req_cycles", 32'(mon_cnt), 32'(mon_cur.high));
               chk("mem_stable", 32'(mon_stable), 32'h1);
            end
         end

         if (bus.err && !bus.i_ack && !bus.d_ack) begin
            checks++;
            errors++;
            $display("FAIL err_without_ack: err=1 i_ack=0 d_ack=0 at %0t", $time);
         end

         if (bus.i_ack || bus.d_ack) begin
            chk("ack_overlap", 32'(bus.i_ack & bus.d_ack), 32'h0);
            chk("mem_req_in_resp", 32'(bus.mem_req), 32'h0);
            if (ack_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL ack_unexpected: i_ack=%0b d_ack=%0b with no access outstanding",
                        bus.i_ack, bus.d_ack);
            end else begin
               ae = ack_q.pop_front();
               chk("ack_side_d", 32'(bus.d_ack), 32'(ae.is_d));
               chk("err", 32'(bus.err), 32'(ae.err));
               chk("i_rdata", bus.i_rdata, ae.i_rdata);
               chk("d_rdata", bus.d_rdata, ae.d_rdata);
            end
         end
      end
   end

   // One request episode: mode 0 = I only, 1 = D only, 2 = both at once.
   task automatic do_step(input int mode, input logic [31:0] ia, input bit dwe,
                          input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe,
                          input int li, input int ld, input bit early, input bit scramble);
      int need;
      int got;
      if (mode == 0) begin
         predict(1'b0, 1'b0, ia, 32'h0, 4'hF, li);
         m_last_d = 1'b0;
         need     = 1;
      end else if (mode == 1) begin
         predict(1'b1, dwe, da, dwd, dbe, ld);
         m_last_d = 1'b1;
         need     = 1;
      end else begin
         // The first winner alternates; afterwards the loser is served and last_d returns.
         if (!m_last_d) begin
            predict(1'b1, dwe, da, dwd, dbe, ld);
            predict(1'b0, 1'b0, ia, 32'h0, 4'hF, li);
         end else begin
            predict(1'b0, 1'b0, ia, 32'h0, 4'hF, li);
            predict(1'b1, dwe, da, dwd, dbe, ld);
         end
         need = 2;
      end
      bus.i_addr  = ia;
      bus.d_we    = dwe;
      bus.d_addr  = da;
      bus.d_wdata = dwd;
      bus.d_be    = dbe;
      bus.i_req   = (mode != 1);
      bus.d_req   = (mode != 0);
      got = 0;
      for (int c = 0; c < 60 && got < need; c++) begin
         @(negedge clk);
         if (bus.i_ack) begin
            bus.i_req = 1'b0;
            got++;
         end
         if (bus.d_ack) begin
            bus.d_req = 1'b0;
            got++;
         end else if (bus.busy && mode != 2) begin
            if (early && mode == 1) bus.d_req = 1'b0;
            if (scramble) begin
               bus.i_addr  = $urandom;
               bus.d_addr  = $urandom;
               bus.d_wdata = $urandom;
               bus.d_be    = 4'($urandom);
               bus.d_we    = 1'($urandom);
            end
         end
      end
      if (got < need) begin
         checks++;
         errors++;
         $display("FAIL ack_wait_timeout: got %0d acks expected %0d (mode %0d)", got, need, mode);
         bus.i_req = 1'b0;
         bus.d_req = 1'b0;
      end
   endtask

   function automatic int rand_lat();
      int r;
      r = int'($urandom_range(0, 11));
      if (r == 11) return LONG_WAIT;
      return r % 5;
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) begin
         model_mem[i] = 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101);
         phys_mem[i]  = model_mem[i];
      end
      model_mem[16] = 32'h0062_8293;
      phys_mem[16]  = 32'h0062_8293;
      bus.i_req   = 1'b0;
      bus.i_addr  = 32'h0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h0;
      bus.d_wdata = 32'h0;
      bus.d_be    = 4'h0;
      model_reset();

      repeat (3) @(negedge clk);
      check_idle("reset");
      #2 rst = 1'b0;

      // Both requesting out of reset: D, I, D, I.
      do_step(2, 32'h0000_0200, 1'b0, 32'h0000_0304, 32'h0, 4'hF, 1, 0, 1'b0, 1'b0);
      do_step(2, 32'h0000_0208, 1'b1, 32'h0000_030C, 32'hCAFE_F00D, 4'hF, 0, 2, 1'b0, 1'b0);
      // Single I read, no wait states.
      do_step(0, 32'h0000_0040, 1'b0, 32'h0, 32'h0, 4'h0, 0, 0, 1'b0, 1'b0);
      // Partial D write after two waits, then read it back.
      do_step(1, 32'h0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h3, 0, 2, 1'b0, 1'b0);
      do_step(1, 32'h0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 1'b0, 1'b0);
      // Timeouts: never-ready, then the exact boundary on both sides of it.
      do_step(1, 32'h0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 0, LONG_WAIT, 1'b0, 1'b0);
      do_step(0, 32'h0000_0040, 1'b0, 32'h0, 32'h0, 4'h0, 3, 0, 1'b0, 1'b0);
      do_step(1, 32'h0, 1'b0, 32'h0000_0108, 32'h0, 4'h0, 0, 4, 1'b0, 1'b0);
      do_step(1, 32'h0, 1'b0, 32'h0000_0108, 32'h0, 4'h0, 0, 3, 1'b0, 1'b0);

      // Reset in the middle of an access, with an I request waiting behind it.
      predict(1'b1, 1'b0, 32'h0000_03F0, 32'h0, 4'hF, LONG_WAIT);
      bus.d_we   = 1'b0;
      bus.d_addr = 32'h0000_03F0;
      bus.d_req  = 1'b1;
      for (int c = 0; c < 20 && !bus.mem_req; c++) @(negedge clk);
      chk("rst_test_mem_req_seen", 32'(bus.mem_req), 32'h1);
      @(negedge clk);
      #2;
      rst        = 1'b1;
      bus.d_req  = 1'b0;
      bus.i_addr = 32'h0000_0044;
      bus.i_req  = 1'b1;
      #1 check_idle("rst_mid");
      model_reset();
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      do_step(0, 32'h0000_0044, 1'b0, 32'h0, 32'h0, 4'h0, 1, 0, 1'b0, 1'b0);

      // D request dropped right after grant still completes.
      do_step(1, 32'h0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 3, 1'b1, 1'b0);

      for (int s = 0; s < 60; s++) begin
         int          mode;
         logic [31:0] ia;
         logic [31:0] da;
         logic [31:0] dwd;
         bit          dwe;
         logic [3:0]  dbe;
         mode = int'($urandom_range(0, 2));
         ia   = {22'h0, 8'($urandom), 2'b00};
         da   = {22'h0, 8'($urandom), 2'b00};
         dwd  = $urandom;
         dwe  = 1'($urandom);
         dbe  = 4'($urandom);
         do_step(mode, ia, dwe, da, dwd, dbe, rand_lat(), rand_lat(),
                 (mode == 1) && ($urandom_range(0, 3) == 0), 1'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      chk("final_mem_q_empty", 32'(mem_q.size()), 32'h0);
      chk("final_ack_q_empty", 32'(ack_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: bench did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "global timeout");
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified, variable-latency memory port between the pipelined CPU's instruction-fetch requester (I, read-only) and its data requester (D, read/write).
- Arbitrates round-robin, sequences each access through a small FSM and returns a one-cycle acknowledge.
- A watchdog aborts accesses whose memory never responds.
- Sits between the CPU core (IF and MEM stages, whose stall logic keys off ack) and the memory/bus.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT, 255, ISSUE-state cycles without mem_ready before abort; legal range 1..2^16-1.
- ERR_DATA, 32'h0000_0000, read data returned on an aborted access.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  instruction read request, level.
- i_addr  in  ADDR_W  instruction address.
- i_ack  out  1  one-cycle completion pulse for I.
- i_rdata  out  DATA_W  instruction data; valid while i_ack=1.
- d_req  in  1  data request, level.
- d_we  in  1  1=write, 0=read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_be  in  DATA_W/8  byte enables; meaningful on writes only.
- d_ack  out  1  one-cycle completion pulse for D.
- d_rdata  out  DATA_W  load data; valid while d_ack=1.
- err  out  1  access aborted by timeout; qualifies the accompanying i_ack/d_ack.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables; all ones on reads.
- mem_ready  in  1  memory completion; sampled only while mem_req=1.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ready.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values:
  - state=IDLE, last_d=0.
  - All outputs 0, including mem_* and rdata registers.
  - Watchdog counter = 0.
  - Reset asserted mid-access drops mem_req immediately; the transaction is lost and no ack is issued.
- FSM states: IDLE, ISSUE, RESP. All outputs are registered.
- IDLE:
  - If i_req|d_req: grant per arbitration and latch into mem_* registers.
    - I grant: addr from i_addr, we=0, be all ones.
    - D grant: addr/we/wdata/be from the d_* inputs.
  - Clear the watchdog, go to ISSUE.
  - mem_req=1 from the next cycle.
- Arbitration (IDLE only):
  - Only one requester: grant it.
  - Both requesting: grant D if last_d=0, else I.
  - last_d updates on each grant (1 = D granted).
  - Out of reset with both requesting, D wins first.
- ISSUE:
  - mem_req=1 and mem_* stay stable.
  - Completion: mem_ready=1 → capture mem_rdata into the granted side's rdata register (writes leave rdata unchanged), drop mem_req, go to RESP.
  - Timeout: watchdog increments each ISSUE cycle without ready. When it reaches TIMEOUT-1 without ready, the next edge drops mem_req, loads ERR_DATA into the granted rdata, sets err, and goes to RESP.
  - mem_ready on the cycle the count hits TIMEOUT-1 takes precedence as a normal completion.
  - Example: TIMEOUT=4 means mem_req is high for 4 cycles, then abort.
- RESP:
  - Granted ack=1 for exactly one cycle; err valid in the same cycle.
  - Requests are ignored in RESP; the FSM returns to IDLE.
  - err clears when RESP exits.
- Latency and throughput:
  - Grant at edge N; mem_req high in cycle N+1.
  - Ready sampled at edge N+1+k; ack high in the following cycle.
  - Minimum request-to-ack is 2 cycles; back-to-back throughput is one access per 3+k cycles.
- Requester rules:
  - Hold req until ack. Address and data are latched at grant, so later changes are ignored.
  - Deasserting req before ack does not abort; ack is still pulsed.
  - A req still high in the cycle after ack is a new request.
- i_ack and d_ack are never high simultaneously; mem_req is never high in IDLE or RESP.

Test Plan:
- Single I read, mem_ready 0 wait states, i_addr=0x0000_0040, mem_rdata=0x0062_8293 → mem_req 1 cycle, mem_be=0xF, i_ack in cycle 3 with i_rdata=0x0062_8293, err=0.
- Single D write, d_addr=0x100, d_wdata=0xDEAD_BEEF, d_be=0x3, memory ready after 2 waits → mem_we=1, mem_be=0x3, stable for 3 cycles; d_ack one cycle; i_ack stays 0.
- i_req and d_req held high together for 4 accesses out of reset → grant order D, I, D, I; i_ack/d_ack never overlap.
- TIMEOUT=4, mem_ready tied 0, D read → mem_req high exactly 4 cycles, then d_ack=1, err=1, d_rdata=0x0; next access completes normally with err=0.
- Assert rst while in ISSUE with mem_req=1 → mem_req, busy, acks all 0 immediately; after release, a pending i_req is granted with no stale ack.
- d_req dropped one cycle after grant, memory ready after 3 waits → access completes, d_ack still pulses once, FSM returns to IDLE.
